// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and LSU access-formatting helpers for the RAM data-port sequencer.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] lane_be(input logic [2:0] funct3, input logic [1:0] a);
    case (funct3)
      F3_B, F3_BU: lane_be = 4'b0001 << a;
      F3_H, F3_HU: lane_be = 4'b0011 << a;
      F3_W:        lane_be = 4'b1111;
      default:     lane_be = 4'b0000;
    endcase
  endfunction

  // Store data is replicated so every enabled lane sees the LSB-aligned value.
  function automatic logic [31:0] lane_wdata(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      F3_B:    lane_wdata = {4{wdata[7:0]}};
      F3_H:    lane_wdata = {2{wdata[15:0]}};
      default: lane_wdata = wdata;
    endcase
  endfunction

  function automatic logic lsu_bad(input logic [2:0] funct3, input logic we, input logic [1:0] a);
    case (funct3)
      F3_B:    lsu_bad = 1'b0;
      F3_BU:   lsu_bad = we;
      F3_H:    lsu_bad = a[0];
      F3_HU:   lsu_bad = a[0] | we;
      F3_W:    lsu_bad = (a != 2'b00);
      default: lsu_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] funct3, input logic [1:0] a,
                                           input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {a, 3'b000};
    case (funct3)
      F3_B:    load_ext = {{24{sh[7]}}, sh[7:0]};
      F3_H:    load_ext = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   load_ext = {24'h0, sh[7:0]};
      F3_HU:   load_ext = {16'h0, sh[15:0]};
      default: load_ext = word;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last.
module mem_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_one;

  always_comb begin
    gnt = 2'b00;
    if (en && clk_en) begin
      if (req[0] && (!req[1] || last_one)) gnt[0] = 1'b1;
      else if (req[1])                     gnt[1] = 1'b1;
    end
  end

  // Reset as if requester 1 was served last, so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_one <= 1'b1;
    else if (|gnt) last_one <= gnt[1];
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// RAM data-port sequencer shared by the LSU and the program loader, one access in flight.
// Define MEM_CONSOLE_EN to turn LSU byte stores to CONSOLE_ADDR into simulation console output.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                RAM_AW       = 10,
  parameter logic [ADDR_W-1:0] CONSOLE_ADDR = 'h200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_funct3,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_gnt,
  output logic              lsu_rsp_valid,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_err,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [RAM_AW-1:0] ldr_addr,
  input  logic [31:0]       ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rsp_valid,
  output logic [31:0]       ldr_rdata,
  output logic              ram_read_req,
  output logic [RAM_AW-1:0] ram_read_addr,
  input  logic [31:0]       ram_read_data,
  output logic              ram_write_en,
  output logic [3:0]        ram_byte_en,
  output logic [RAM_AW-1:0] ram_write_addr,
  output logic [31:0]       ram_write_data
);

  mem_state_e        state;
  logic [1:0]        gnt;
  logic              bad;
  logic [3:0]        be_lsu;
  logic              console_hit;
  logic              owner_p0;
  logic              we_p0;
  logic              err_p0;
  logic              console_p0;
  logic [2:0]        f3_p0;
  logic [1:0]        a_p0;
  logic [RAM_AW-1:0] idx_p0;
  logic [3:0]        be_p0;
  logic [31:0]       wdata_p0;
  logic [31:0]       rdata_p2;
  logic              wr_stb;
  logic              rd_stb;
  logic              rsp;
  logic              unused_addr_hi;

  mem_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .en     (state == IDLE),
    .req    ({ldr_req, lsu_req}),
    .gnt    (gnt)
  );

  assign bad    = lsu_bad(lsu_funct3, lsu_we, lsu_addr[1:0]);
  assign be_lsu = lane_be(lsu_funct3, lsu_addr[1:0]);
  assign unused_addr_hi = ^lsu_addr[ADDR_W-1:RAM_AW+2];

`ifdef MEM_CONSOLE_EN
  assign console_hit = lsu_we & be_lsu[0] & ~bad & (lsu_addr == CONSOLE_ADDR);

  always_ff @(posedge clk) begin
    if (clk_en && state == ISSUE && console_p0) $write("%c", wdata_p0[7:0]);
  end
`else
  assign console_hit = 1'b0;
`endif

  // C0: grant and latch; a bad LSU access skips the RAM and answers in C1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner_p0   <= 1'b0;
      we_p0      <= 1'b0;
      err_p0     <= 1'b0;
      console_p0 <= 1'b0;
    end else if (clk_en) begin
      case (state)
        IDLE: if (|gnt) begin
          owner_p0   <= gnt[1];
          we_p0      <= gnt[1] ? ldr_we : lsu_we;
          err_p0     <= gnt[0] & bad;
          console_p0 <= gnt[0] & console_hit;
          state      <= (gnt[0] & bad) ? RESP : ISSUE;
        end
        ISSUE:   state <= we_p0 ? RESP : WAIT;
        WAIT:    state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (|gnt) begin
      if (gnt[1]) begin
        f3_p0    <= F3_W;
        a_p0     <= 2'b00;
        idx_p0   <= ldr_addr;
        be_p0    <= 4'b1111;
        wdata_p0 <= ldr_wdata;
      end else begin
        f3_p0    <= lsu_funct3;
        a_p0     <= lsu_addr[1:0];
        idx_p0   <= lsu_addr[RAM_AW+1:2];
        be_p0    <= be_lsu;
        wdata_p0 <= lane_wdata(lsu_funct3, lsu_wdata);
      end
      rdata_p2 <= '0;
    // C2: the registered RAM word arrives and is extended.
    end else if (clk_en && state == WAIT) begin
      rdata_p2 <= load_ext(f3_p0, a_p0, ram_read_data);
    end
  end

  // C1: RAM strobes come straight from the latched access.
  assign wr_stb = (state == ISSUE) & we_p0 & ~console_p0;
  assign rd_stb = (state == ISSUE) & ~we_p0;
  assign rsp    = (state == RESP);

  assign ram_write_en   = wr_stb;
  assign ram_byte_en    = wr_stb ? be_p0 : 4'b0000;
  assign ram_write_addr = wr_stb ? idx_p0 : '0;
  assign ram_write_data = wr_stb ? wdata_p0 : 32'h0;
  assign ram_read_req   = rd_stb;
  assign ram_read_addr  = rd_stb ? idx_p0 : '0;

  assign lsu_gnt       = gnt[0];
  assign ldr_gnt       = gnt[1];
  assign lsu_rsp_valid = rsp & ~owner_p0;
  assign ldr_rsp_valid = rsp & owner_p0;
  assign lsu_rdata     = lsu_rsp_valid ? rdata_p2 : 32'h0;
  assign lsu_err       = lsu_rsp_valid & err_p0;
  assign ldr_rdata     = ldr_rsp_valid ? rdata_p2 : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, randomized traffic against a byte-level model, corner sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst, clk_en;
  logic        lsu_req, lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_gnt, lsu_rsp_valid, lsu_err;
  logic [31:0] lsu_rdata;
  logic        ldr_req, ldr_we;
  logic [9:0]  ldr_addr;
  logic [31:0] ldr_wdata;
  logic        ldr_gnt, ldr_rsp_valid;
  logic [31:0] ldr_rdata;
  logic        ram_read_req, ram_write_en;
  logic [9:0]  ram_read_addr, ram_write_addr;
  logic [31:0] ram_read_data, ram_write_data;
  logic [3:0]  ram_byte_en;
  logic        any_out;

  int n_chk = 0;
  int n_pass = 0;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt), .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rsp_valid(ldr_rsp_valid), .ldr_rdata(ldr_rdata),
    .ram_read_req(ram_read_req), .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data),
    .ram_write_en(ram_write_en), .ram_byte_en(ram_byte_en), .ram_write_addr(ram_write_addr),
    .ram_write_data(ram_write_data)
  );

  always #5 clk = ~clk;

  assign any_out = |{lsu_gnt, lsu_rsp_valid, lsu_rdata, lsu_err, ldr_gnt, ldr_rsp_valid, ldr_rdata,
                     ram_read_req, ram_read_addr, ram_write_en, ram_byte_en, ram_write_addr,
                     ram_write_data};

  // Byte-lane RAM with a registered read port.
  logic [31:0] mem [1024];
  logic [31:0] rd_q;
  assign ram_read_data = rd_q;
  always @(posedge clk) begin
    if (ram_write_en)
      for (int i = 0; i < 4; i++)
        if (ram_byte_en[i]) mem[ram_write_addr][8*i +: 8] <= ram_write_data[8*i +: 8];
    if (ram_read_req) rd_q <= mem[ram_read_addr];
  end

  // Reference memory kept as plain bytes.
  logic [7:0] refm [4096];

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          lat;
    bit          wr;
    bit          rd;
    logic [3:0]  be;
    logic [31:0] wdo;
    logic [9:0]  widx;
  } res_t;

  typedef struct {
    bit          ldr;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          err;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wdo;
    int          lat;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
  endtask

  task automatic model(input bit ldr, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output res_t e);
    int a, sz, b;
    longint v;
    bit bad;
    e = '{default: 0};
    if (ldr) begin
      b = int'(addr[9:0]) * 4;
      if (we) begin
        for (int i = 0; i < 4; i++) refm[b + i] = 8'((wd >> (8 * i)) & 32'hFF);
        e.wr = 1; e.be = 4'hF; e.wdo = wd; e.widx = addr[9:0]; e.lat = 2;
      end else begin
        e.rd = 1; e.rdata = {refm[b + 3], refm[b + 2], refm[b + 1], refm[b]}; e.lat = 3;
      end
      return;
    end
    a   = int'(addr % 4);
    b   = int'(addr % 4096);
    sz  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    bad = (f3 == 3 || f3 == 6 || f3 == 7) || (we && f3 >= 4) || (a % sz != 0);
    if (bad) begin
      e.err = 1; e.lat = 1;
    end else if (we) begin
      for (int i = 0; i < sz; i++) refm[b + i] = 8'((wd >> (8 * i)) & 32'hFF);
      e.wr   = 1;
      e.be   = 4'(((1 << sz) - 1) << a);
      e.wdo  = (sz == 1) ? (wd & 32'hFF) * 32'h01010101 :
               (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
      e.widx = 10'((addr / 4) % 1024);
      e.lat  = 2;
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++) v += longint'(refm[b + i]) << (8 * i);
      if (f3 < 4 && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
      e.rd = 1; e.rdata = v[31:0]; e.lat = 3;
    end
  endtask

  // Issues one access starting at posedge+1 and returns at posedge+1 after its response.
  task automatic txn(input bit ldr, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, output res_t r);
    bit got;
    int c;
    r = '{default: 0};
    r.lat = -1;
    got = 0;
    c = 0;
    if (ldr) begin
      ldr_req = 1; ldr_we = we; ldr_addr = addr[9:0]; ldr_wdata = wd;
    end else begin
      lsu_req = 1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
    end
    for (int k = 0; k < 12; k++) begin
      #3;
      if (!got && (ldr ? ldr_gnt : lsu_gnt)) got = 1;
      if (ram_write_en) begin
        r.wr = 1; r.be = ram_byte_en; r.wdo = ram_write_data; r.widx = ram_write_addr;
      end
      if (ram_read_req) r.rd = 1;
      if (ldr ? ldr_rsp_valid : lsu_rsp_valid) begin
        r.lat = c; r.rdata = ldr ? ldr_rdata : lsu_rdata; r.err = ldr ? 1'b0 : lsu_err;
      end
      @(posedge clk); #1;
      if (got) begin lsu_req = 0; ldr_req = 0; c++; end
      if (r.lat >= 0) break;
    end
    lsu_req = 0;
    ldr_req = 0;
  endtask

  task automatic compare(input string nm, input res_t act, input res_t exp_r);
    chk({nm, ".lat"}, act.lat, exp_r.lat);
    chk({nm, ".err"}, 32'(act.err), 32'(exp_r.err));
    chk({nm, ".rdata"}, act.rdata, exp_r.rdata);
    chk({nm, ".wr"}, 32'(act.wr), 32'(exp_r.wr));
    chk({nm, ".rd"}, 32'(act.rd), 32'(exp_r.rd));
    if (exp_r.wr) begin
      chk({nm, ".be"}, 32'(act.be), 32'(exp_r.be));
      chk({nm, ".wdata"}, act.wdo, exp_r.wdo);
      chk({nm, ".widx"}, 32'(act.widx), 32'(exp_r.widx));
    end
  endtask

  initial begin
    res_t r, e;
    int ng, outst, nrsp;
    bit overlap;
    bit order [4];
    bit ldr, we;
    logic [2:0] f3;
    logic [31:0] addr, wd;

    tbl[0]  = '{0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0,        4'hF, 32'hDEADBEEF, 2};
    tbl[1]  = '{0, 0, 3'b010, 32'h10, 32'h0,        0, 32'hDEADBEEF, 4'h0, 32'h0,        3};
    tbl[2]  = '{1, 1, 3'b010, 32'h4,  32'h80FF7F01, 0, 32'h0,        4'hF, 32'h80FF7F01, 2};
    tbl[3]  = '{1, 0, 3'b010, 32'h4,  32'h0,        0, 32'h80FF7F01, 4'h0, 32'h0,        3};
    tbl[4]  = '{0, 0, 3'b000, 32'h11, 32'h0,        0, 32'h0000007F, 4'h0, 32'h0,        3};
    tbl[5]  = '{0, 0, 3'b100, 32'h12, 32'h0,        0, 32'h000000FF, 4'h0, 32'h0,        3};
    tbl[6]  = '{0, 0, 3'b001, 32'h12, 32'h0,        0, 32'hFFFF80FF, 4'h0, 32'h0,        3};
    tbl[7]  = '{0, 0, 3'b101, 32'h12, 32'h0,        0, 32'h000080FF, 4'h0, 32'h0,        3};
    tbl[8]  = '{0, 1, 3'b000, 32'h13, 32'h123456AB, 0, 32'h0,        4'h8, 32'hABABABAB, 2};
    tbl[9]  = '{0, 1, 3'b001, 32'h12, 32'hFFFF1234, 0, 32'h0,        4'hC, 32'h12341234, 2};
    tbl[10] = '{0, 0, 3'b010, 32'h10, 32'h0,        0, 32'h12347F01, 4'h0, 32'h0,        3};
    tbl[11] = '{0, 0, 3'b010, 32'h12, 32'h0,        1, 32'h0,        4'h0, 32'h0,        1};
    tbl[12] = '{0, 1, 3'b001, 32'h11, 32'h5555,     1, 32'h0,        4'h0, 32'h0,        1};
    tbl[13] = '{0, 0, 3'b011, 32'h10, 32'h0,        1, 32'h0,        4'h0, 32'h0,        1};
    tbl[14] = '{0, 1, 3'b100, 32'h10, 32'h77,       1, 32'h0,        4'h0, 32'h0,        1};

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4096; i++) refm[i] = 8'h0;
    rst = 1; clk_en = 1;
    lsu_req = 0; lsu_we = 0; lsu_funct3 = 0; lsu_addr = 0; lsu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(any_out), 32'h0);
    rst = 0;

    // Directed vectors.
    for (int i = 0; i < 15; i++) begin
      model(tbl[i].ldr, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, e);
      e.err   = tbl[i].err;
      e.rdata = tbl[i].rdata;
      e.lat   = tbl[i].lat;
      e.wr    = tbl[i].we && !tbl[i].err;
      e.rd    = !tbl[i].we && !tbl[i].err;
      e.be    = tbl[i].be;
      e.wdo   = tbl[i].wdo;
      e.widx  = tbl[i].ldr ? tbl[i].addr[9:0] : 10'((tbl[i].addr >> 2) % 1024);
      txn(tbl[i].ldr, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, r);
      compare($sformatf("vec%0d", i), r, e);
    end

    // Randomized traffic from both requesters.
    for (int i = 0; i < 80; i++) begin
      ldr  = ($urandom_range(0, 3) == 0);
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = ldr ? 32'($urandom_range(0, 15)) : (($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63)));
      wd   = $urandom;
      model(ldr, we, f3, addr, wd, e);
      txn(ldr, we, f3, addr, wd, r);
      compare($sformatf("rnd%0d", i), r, e);
    end

    // clk_en low holds off the grant; the request then proceeds once enabled.
    clk_en = 0;
    lsu_req = 1; lsu_we = 0; lsu_funct3 = 3'b010; lsu_addr = 32'h10;
    #3;
    chk("clken.no_gnt0", 32'(lsu_gnt), 32'h0);
    @(posedge clk); #1;
    #3;
    chk("clken.no_gnt1", 32'(lsu_gnt), 32'h0);
    @(posedge clk); #1;
    clk_en = 1;
    model(0, 0, 3'b010, 32'h10, 32'h0, e);
    txn(0, 0, 3'b010, 32'h10, 32'h0, r);
    compare("clken.load", r, e);

    // Both requesters from reset alternate, one access at a time.
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    lsu_we = 0; lsu_funct3 = 3'b010; lsu_addr = 32'h10; ldr_we = 0; ldr_addr = 10'd4;
    lsu_req = 1; ldr_req = 1;
    ng = 0; outst = 0; overlap = 0;
    for (int k = 0; k < 60 && !(ng == 4 && outst == 0); k++) begin
      #3;
      if (lsu_rsp_valid || ldr_rsp_valid) outst = 0;
      if (lsu_gnt || ldr_gnt) begin
        if (outst != 0 || (lsu_gnt && ldr_gnt)) overlap = 1;
        if (ng < 4) order[ng] = ldr_gnt;
        ng++;
        outst = 1;
      end
      @(posedge clk); #1;
      if (ng >= 4) begin lsu_req = 0; ldr_req = 0; end
    end
    lsu_req = 0; ldr_req = 0;
    chk("arb.grants", ng, 4);
    chk("arb.one_in_flight", 32'(overlap), 32'h0);
    for (int k = 0; k < 4; k++) chk($sformatf("arb.order%0d", k), 32'(order[k]), k % 2);
    @(posedge clk); #1;

    // Reset while the read is in WAIT drops the access with no response.
    lsu_req = 1; lsu_we = 0; lsu_funct3 = 3'b010; lsu_addr = 32'h10;
    #3;
    chk("rstw.gnt", 32'(lsu_gnt), 32'h1);
    @(posedge clk); #1;
    lsu_req = 0;
    #3;
    chk("rstw.read_req", 32'(ram_read_req), 32'h1);
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("rstw.outputs", 32'(any_out), 32'h0);
    @(posedge clk); #1;
    rst = 0;
    nrsp = 0;
    for (int k = 0; k < 6; k++) begin
      #3;
      if (lsu_rsp_valid || ldr_rsp_valid) nrsp++;
      @(posedge clk); #1;
    end
    chk("rstw.no_rsp", nrsp, 0);

`ifdef MEM_CONSOLE_EN
    txn(0, 1, 3'b000, 32'h200, 32'h41, r);
    chk("console.no_write", 32'(r.wr), 32'h0);
    chk("console.lat", r.lat, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
